soc_system_pio_in_edge: RTL
===========================

# soc_system_pio_in_edge

Parametrised Avalon-MM input PIO that succeeds the fixed 8-bit read-only data port in the soc_system Qsys fabric. It synchronises an asynchronous input bus, exposes its level, latches edges per bit into a sticky capture register, and raises a maskable level interrupt to the HPS/Nios interrupt controller. Sits on the lightweight HPS-to-FPGA bridge as an s1 slave with read latency 1.

## Interface
Parameters:
- DATA_WIDTH, 8, input bus width; legal 1..32.
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2, synchroniser depth on in_port; legal 2..4.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- address  in  3  Avalon word address.
- chipselect  in  1  slave select; qualifies write.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  DATA_WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.

## Operation
- Register map (word offsets): 0 DATA (RO, synchronised level), 1 reserved (reads 0), 2 IRQMASK (RW), 3 EDGECAP (read; write-1-to-clear). Offsets 4..7 read 0, writes ignored.
- Write accepted when chipselect=1 and write_n=0; only writedata[DATA_WIDTH-1:0] used. Writes to 0/1 ignored.
- Synchroniser: SYNC_STAGES flops, all reset to 0; output sync_q. One further register prev_q holds sync_q delayed one cycle.
- Edge detect: rise = sync_q & ~prev_q; fall = ~sync_q & prev_q; det selected by EDGE_TYPE (any = rise|fall).
- Arm counter: after reset release, edge detection is suppressed until SYNC_STAGES+1 cycles have elapsed (counter saturates, state ARMING -> ARMED). Prevents spurious capture of inputs already high at reset.
- EDGECAP update per bit: next = (cap & ~clr) | det_armed. Set wins over simultaneous clear.
- irq = |(EDGECAP & IRQMASK), driven from registered state only (no combinational path from bus).
- readdata mux: zero-extended to 32 bits; unused upper bits always 0.

## Timing
- Reset values: readdata 0, irq 0, IRQMASK 0, EDGECAP 0, sync/prev flops 0, arm state ARMING.
- Read latency 1: readdata loaded every clock from address (chipselect not required), valid the cycle after address presented.
- in_port change to DATA visible in readdata: SYNC_STAGES+1 cycles (plus setup uncertainty of one cycle).
- in_port change to EDGECAP bit set: SYNC_STAGES+1 cycles; irq asserts same cycle as EDGECAP bit if mask bit set.
- Write to IRQMASK/EDGECAP takes effect next clock edge; irq follows in that same cycle.
- Pulses shorter than one clk period may be missed; no guarantee.
- reset_n assertion mid-operation clears all state immediately (asynchronous), re-enters ARMING.

## Structure
- Shared package soc_system_pio_pkg: register offset constants (PIO_DATA=0, PIO_IRQMASK=2, PIO_EDGECAP=3), EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- One sub-module: soc_system_pio_sync (parametrised width and depth, async active-low reset, flop chain only); reused by future output/bidir PIO variants.
- Top holds arm counter, edge logic, registers, read mux.

## Test plan
- Reset with in_port=8'hFF held, release, wait 10 cycles -> DATA reads 8'hFF, EDGECAP reads 0, irq=0 (arm suppression).
- EDGE_TYPE=0: in_port 8'h00 -> 8'h05, IRQMASK=8'h04 -> EDGECAP=8'h05 after SYNC_STAGES+1 cycles, irq=1; write EDGECAP 8'h04 -> reads 8'h01, irq=0.
- EDGE_TYPE=1 and 2 variants: 8'h0F -> 8'h00 captures 8'h0F; with rising mode same stimulus captures 8'h00.
- Simultaneous write-1-clear of bit 3 with new edge on bit 3 in same cycle -> bit 3 remains 1.
- DATA_WIDTH=32, in_port=32'hDEADBEEF -> DATA reads 32'hDEADBEEF; DATA_WIDTH=5 -> readdata[31:5]=0 at all offsets; offsets 1,4..7 read 0.
- Assert reset_n mid-capture with EDGECAP=8'hAA, IRQMASK=8'hFF -> irq, readdata, EDGECAP, IRQMASK all 0 without waiting for clk edge.

Source files
------------

// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the soc_system PIO family: register offsets,
// edge-capture mode encodings and the arm-state type.
package soc_system_pio_pkg;

    localparam logic [2:0] PIO_DATA    = 3'd0;
    localparam logic [2:0] PIO_IRQMASK = 3'd2;
    localparam logic [2:0] PIO_EDGECAP = 3'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    typedef enum logic {
        ARM_ARMING = 1'b0,
        ARM_ARMED  = 1'b1
    } arm_state_e;

endpackage

// File: rtl/soc_system_pio_sync.sv
// Plain flop-chain synchroniser for asynchronous PIO inputs; all stages
// clear to zero on reset.
module soc_system_pio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // Shift the input through the synchroniser chain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/soc_system_pio_in_edge.sv
// Avalon-MM input PIO: synchronised level, sticky per-bit edge capture with
// write-1-to-clear, maskable level interrupt, read latency 1.
module soc_system_pio_in_edge
    import soc_system_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam logic [2:0] ARM_LAST = 3'(SYNC_STAGES);

    logic [DATA_WIDTH-1:0] sync_s;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] rise_s;
    logic [DATA_WIDTH-1:0] fall_s;
    logic [DATA_WIDTH-1:0] det_s;
    logic [DATA_WIDTH-1:0] det_armed_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [DATA_WIDTH-1:0] clr_s;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  irq_q, irq_d;
    logic                  wr_en_s;
    logic                  unused_wr_s;
    arm_state_e            arm_state_q, arm_state_d;
    logic [2:0]            arm_cnt_q, arm_cnt_d;

    soc_system_pio_sync #(
        .WIDTH  (DATA_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .d_i     (in_port),
        .q_o     (sync_s)
    );

    assign wr_en_s     = chipselect & ~write_n;
    assign wdata_s     = writedata[DATA_WIDTH-1:0];
    assign unused_wr_s = ^(writedata >> DATA_WIDTH);

    // Arm sequencing: hold off capture until the synchroniser and prev stage
    // have filled, so inputs already high at reset do not look like edges.
    always_comb begin
        arm_state_d = arm_state_q;
        arm_cnt_d   = arm_cnt_q;
        case (arm_state_q)
            ARM_ARMING: begin
                if (arm_cnt_q == ARM_LAST) begin
                    arm_state_d = ARM_ARMED;
                end else begin
                    arm_cnt_d = arm_cnt_q + 3'd1;
                end
            end
            ARM_ARMED: begin
                arm_state_d = ARM_ARMED;
            end
            default: begin
                arm_state_d = ARM_ARMING;
                arm_cnt_d   = 3'd0;
            end
        endcase
    end

    // Arm state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_state_q <= ARM_ARMING;
            arm_cnt_q   <= 3'd0;
        end else begin
            arm_state_q <= arm_state_d;
            arm_cnt_q   <= arm_cnt_d;
        end
    end

    // Edge detection for the configured mode, gated by the arm state.
    always_comb begin
        rise_s = sync_s & ~prev_q;
        fall_s = ~sync_s & prev_q;
        case (EDGE_TYPE)
            EDGE_FALL: det_s = fall_s;
            EDGE_ANY:  det_s = rise_s | fall_s;
            default:   det_s = rise_s;
        endcase
        if (arm_state_q == ARM_ARMED) begin
            det_armed_s = det_s;
        end else begin
            det_armed_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Bus writes, capture update (set wins over clear), irq and read mux.
    always_comb begin
        mask_d = mask_q;
        clr_s  = {DATA_WIDTH{1'b0}};
        if (wr_en_s) begin
            case (address)
                PIO_IRQMASK: mask_d = wdata_s;
                PIO_EDGECAP: clr_s  = wdata_s;
                default:     mask_d = mask_q;
            endcase
        end else begin
            mask_d = mask_q;
        end
        cap_d = (cap_q & ~clr_s) | det_armed_s;
        irq_d = |(cap_d & mask_d);
        case (address)
            PIO_DATA:    readdata_d = 32'(sync_s);
            PIO_IRQMASK: readdata_d = 32'(mask_q);
            PIO_EDGECAP: readdata_d = 32'(cap_q);
            default:     readdata_d = 32'd0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= {DATA_WIDTH{1'b0}};
            mask_q     <= {DATA_WIDTH{1'b0}};
            cap_q      <= {DATA_WIDTH{1'b0}};
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= sync_s;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
